usbdev_line_mon: RTL

Full-speed USB line monitor that conditions the raw D+/D- pins into a qualified line state. It generates the 1 µs tick, the J-detect pulse and the bus-idle level consumed by the link-state tracker, and can optionally count SE1 line errors. It sits between the pin/PHY interface and the link-state and suspend/reset detection logic, in the 48 MHz domain.

---
 rtl/usbdev_pkg.sv | 37 +++
 rtl/usbdev_line_mon_if.sv | 42 ++++
 rtl/usbdev_us_tick.sv | 29 ++
 rtl/usbdev_line_mon.sv | 107 ++++++++++
 4 files changed

// File: rtl/usbdev_pkg.sv
// Shared types and constants for the usbdev 48 MHz domain: line states, line-monitor
// FSM states, microsecond tick period and the raw D+/D- decode helper.
package usbdev_pkg;

  typedef enum logic [1:0] {
    LineSe0 = 2'd0,
    LineJ   = 2'd1,
    LineK   = 2'd2,
    LineSe1 = 2'd3
  } line_state_e;

  typedef enum logic [1:0] {
    LmDrive,
    LmActive,
    LmJCount,
    LmIdle
  } line_mon_state_e;

  localparam int unsigned UsTickCycles = 48;
  localparam int unsigned UsTickW      = 6;

  // Pinflip swaps which physical pin is treated as D+.
  function automatic line_state_e decode_line(logic dp, logic dn, logic pinflip);
    logic [1:0]  pins;
    line_state_e ls;
    pins = pinflip ? {dn, dp} : {dp, dn};
    ls   = LineSe0;
    unique case (pins)
      2'b10:   ls = LineJ;
      2'b01:   ls = LineK;
      2'b11:   ls = LineSe1;
      default: ls = LineSe0;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usbdev_line_mon_if.sv
// Pin-side and status signals of the USB line monitor. The master modport is the
// PHY/consumer side; the slave modport is the monitor itself.
interface usbdev_line_mon_if;

  logic       usb_dp_i;
  logic       usb_dn_i;
  logic       usb_oe_i;
  logic       cfg_pinflip_i;
  logic       se1_clr_i;
  logic       us_tick_o;
  logic [1:0] line_state_o;
  logic       rx_j_det_o;
  logic       rx_idle_det_o;
  logic [7:0] se1_count_o;

  modport master (
    output usb_dp_i,
    output usb_dn_i,
    output usb_oe_i,
    output cfg_pinflip_i,
    output se1_clr_i,
    input  us_tick_o,
    input  line_state_o,
    input  rx_j_det_o,
    input  rx_idle_det_o,
    input  se1_count_o
  );

  modport slave (
    input  usb_dp_i,
    input  usb_dn_i,
    input  usb_oe_i,
    input  cfg_pinflip_i,
    input  se1_clr_i,
    output us_tick_o,
    output line_state_o,
    output rx_j_det_o,
    output rx_idle_det_o,
    output se1_count_o
  );

endinterface

// File: rtl/usbdev_us_tick.sv
// Free-running 1 us tick for the 48 MHz domain: counts 0..UsTickCycles-1 and pulses
// tick_o for one cycle while the count sits at its last value.
module usbdev_us_tick
  import usbdev_pkg::*;
(
  input  logic clk_48mhz_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam logic [UsTickW-1:0] CntMax = UsTickW'(UsTickCycles - 1);

  logic [UsTickW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/usbdev_line_mon.sv
// Full-speed USB line monitor: glitch-qualified line state, J-detect pulse, bus-idle
// level and 1 us tick. Optional SE1 error counter enabled by USBDEV_LINE_MON_SE1_CNT_EN.
module usbdev_line_mon
  import usbdev_pkg::*;
#(
  parameter int unsigned IdleBits = 7
) (
  input  logic              clk_48mhz_i,
  input  logic              rst_ni,
  usbdev_line_mon_if.slave  bus
);

  // Last count value spent in LmJCount before declaring idle.
  localparam logic [5:0] JTerm = 6'(IdleBits * 4 - 1);

  line_state_e     raw_d, raw_q;
  line_state_e     line_d, line_q;
  line_mon_state_e state_q;
  logic [5:0]      cnt_q;
  logic            us_tick;

  usbdev_us_tick u_us_tick (
    .clk_48mhz_i (clk_48mhz_i),
    .rst_ni      (rst_ni),
    .tick_o      (us_tick)
  );

  assign raw_d  = decode_line(bus.usb_dp_i, bus.usb_dn_i, bus.cfg_pinflip_i);
  // A value must be seen on two consecutive edges before it is accepted.
  assign line_d = (raw_d == raw_q) ? raw_d : line_q;

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_q  <= LineSe0;
      line_q <= LineSe0;
    end else begin
      raw_q  <= raw_d;
      line_q <= line_d;
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LmActive;
      cnt_q   <= '0;
    end else if (bus.usb_oe_i) begin
      state_q <= LmDrive;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        LmDrive, LmActive: begin
          if (line_q == LineJ) begin
            state_q <= LmJCount;
            cnt_q   <= '0;
          end else begin
            state_q <= LmActive;
          end
        end
        LmJCount: begin
          if (line_q != LineJ) begin
            state_q <= LmActive;
            cnt_q   <= '0;
          end else if (cnt_q == JTerm) begin
            state_q <= LmIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LmIdle: begin
          if (line_q != LineJ) begin
            state_q <= LmActive;
          end
        end
        default: state_q <= LmActive;
      endcase
    end
  end

  assign bus.us_tick_o     = us_tick;
  assign bus.line_state_o  = line_q;
  assign bus.rx_j_det_o    = (state_q == LmJCount) && (cnt_q == '0);
  assign bus.rx_idle_det_o = (state_q == LmIdle);

`ifdef USBDEV_LINE_MON_SE1_CNT_EN
  logic [7:0] se1_cnt_q;
  logic       se1_entry;

  assign se1_entry = (line_d == LineSe1) && (line_q != LineSe1);

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      se1_cnt_q <= '0;
    end else if (bus.se1_clr_i) begin
      se1_cnt_q <= '0;
    end else if (se1_entry && (se1_cnt_q != 8'hff)) begin
      se1_cnt_q <= se1_cnt_q + 1'b1;
    end
  end

  assign bus.se1_count_o = se1_cnt_q;
`else
  logic unused_se1_clr;
  assign unused_se1_clr  = bus.se1_clr_i;
  assign bus.se1_count_o = '0;
`endif

endmodule
